// File: rtl/host_bus_master.sv
// host_bus_master
// Bus-cycle initiator for the FPGA host interface. Converts a valid/ready
// request stream into chip-select/strobe cycles on HOST_nCS/HOST_nWE/HOST_nOE,
// HOST_ADD and HDI, and captures read data from HDO.
//
// Parameters (each 0..15):
//   SETUP_CYC  - nCS low, strobe high, before the strobe (0 skips)
//   STROBE_CYC - nWE/nOE low (minimum 1)
//   HOLD_CYC   - nCS low, strobe high, after the strobe (0 skips)
//   IDLE_CYC   - nCS high recovery after each beat (0 skips)
//
// Ports:
//   clk, nRESET            clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_we, req_wide       1=write / 64-bit access
//   req_addr, req_wdata    byte address (bit 0 ignored), write data
//   rsp_valid, rsp_rdata   one-cycle completion pulse, read data (held)
//   busy                   FSM not in IDLE
//   HOST_nCS/nWE/nOE       active-low bus strobes
//   HOST_ADD, HDI, HDO     bus address, write data, read data
//
// Optional feature macro: HOST_BUS_MASTER_WIDE_EN
//   defined   - req_wide=1 issues four beats (addr, +2, +4, +6), low word first
//   undefined - every access is one 16-bit beat; req_wide and wdata[63:16]
//               are ignored, rsp_rdata[63:16] reads 0
//
// All outputs are registered: the combinational block computes next-state and
// next-output values and both are captured on the same edge.

module host_bus_master #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 3,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned IDLE_CYC   = 1
) (
   input  logic        clk,
   input  logic        nRESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_wide,
   input  logic [20:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        busy,
   output logic        HOST_nCS,
   output logic        HOST_nWE,
   output logic        HOST_nOE,
   output logic [20:0] HOST_ADD,
   output logic [15:0] HDI,
   input  logic [15:0] HDO
);

   localparam int unsigned ADDR_W = 21;
   localparam int unsigned BUS_W  = 16;
   localparam int unsigned RSP_W  = 64;
`ifdef HOST_BUS_MASTER_WIDE_EN
   localparam int unsigned DATA_W = 64;
`else
   localparam int unsigned DATA_W = 16;
`endif

   // Counter load values: a state with count N runs N cycles, loaded with N-1.
   localparam logic [3:0] SETUP_LD  = 4'((SETUP_CYC  == 0) ? 0 : SETUP_CYC  - 1);
   localparam logic [3:0] STROBE_LD = 4'((STROBE_CYC == 0) ? 0 : STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'((HOLD_CYC   == 0) ? 0 : HOLD_CYC   - 1);
   localparam logic [3:0] IDLE_LD   = 4'((IDLE_CYC   == 0) ? 0 : IDLE_CYC   - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   // First state of every beat; SETUP is skipped when it has no cycles.
   localparam state_t     FIRST_ST = (SETUP_CYC != 0) ? SETUP : STROBE;
   localparam logic [3:0] FIRST_LD = (SETUP_CYC != 0) ? SETUP_LD : STROBE_LD;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [1:0]          beat_q, beat_d;
   logic                we_q, we_d;
   logic                wide_q, wide_d;
   logic [ADDR_W-1:0]   baddr_q, baddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rbuf_q, rbuf_d;

   logic                last_beat;
   logic                end_beat;
   logic                next_beat;
   logic                start_beat;
   logic [BUS_W-1:0]    beat_word;

   logic                ncs_d, nwe_d, noe_d;
   logic [ADDR_W-1:0]   add_d;
   logic [BUS_W-1:0]    hdi_d;
   logic                rsp_valid_d;
   logic                ready_d;
   logic                busy_d;

`ifndef HOST_BUS_MASTER_WIDE_EN
   logic unused_wide;
   assign unused_wide = ^{req_wide, req_wdata[63:16]};
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      beat_d      = beat_q;
      we_d        = we_q;
      wide_d      = wide_q;
      baddr_d     = baddr_q;
      wdata_d     = wdata_q;
      rbuf_d      = rbuf_q;
      end_beat    = 1'b0;
      next_beat   = 1'b0;
      start_beat  = 1'b0;
      beat_word   = '0;
      add_d       = HOST_ADD;
      hdi_d       = HDI;
      rsp_valid_d = 1'b0;
      last_beat   = !wide_q || (beat_q == 2'd3);

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
`ifdef HOST_BUS_MASTER_WIDE_EN
               wide_d     = req_wide;
               wdata_d    = req_wdata;
`else
               wide_d     = 1'b0;
               wdata_d    = req_wdata[15:0];
`endif
               baddr_d    = req_addr;
               beat_d     = 2'd0;
               rbuf_d     = '0;
               start_beat = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               // Read data is sampled on the edge that ends the strobe.
               if (!we_q) begin
`ifdef HOST_BUS_MASTER_WIDE_EN
                  rbuf_d[{beat_q, 4'b0000} +: 16] = HDO;
`else
                  rbuf_d = HDO;
`endif
               end
               if (HOLD_CYC != 0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  end_beat = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               end_beat = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RECOVER: begin
            if (cnt_q == 4'd0) begin
               next_beat = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Leaving the bus-active part of a beat.
      if (end_beat) begin
         rsp_valid_d = last_beat;
         if (IDLE_CYC != 0) begin
            state_d = RECOVER;
            cnt_d   = IDLE_LD;
         end else begin
            next_beat = 1'b1;
         end
      end

      // Either finish the access or advance to the next beat address.
      if (next_beat) begin
         if (last_beat) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end else begin
            beat_d     = beat_q + 2'd1;
            baddr_d    = ADDR_W'(baddr_q + 21'd2);
            start_beat = 1'b1;
         end
      end

      // Address and data are launched together with the first state of a beat.
      if (start_beat) begin
         state_d = FIRST_ST;
         cnt_d   = FIRST_LD;
`ifdef HOST_BUS_MASTER_WIDE_EN
         beat_word = wdata_d[{beat_d, 4'b0000} +: 16];
`else
         beat_word = wdata_d;
`endif
         add_d = {baddr_d[ADDR_W-1:1], 1'b0};
         hdi_d = we_d ? beat_word : '0;
      end

      ncs_d   = !((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD));
      nwe_d   = !((state_d == STROBE) && we_d);
      noe_d   = !((state_d == STROBE) && !we_d);
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   // State register
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         beat_q  <= 2'd0;
         we_q    <= 1'b0;
         wide_q  <= 1'b0;
         baddr_q <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         we_q    <= we_d;
         wide_q  <= wide_d;
         baddr_q <= baddr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // Registered outputs; reset forces all strobes high immediately
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         HOST_nCS  <= 1'b1;
         HOST_nWE  <= 1'b1;
         HOST_nOE  <= 1'b1;
         HOST_ADD  <= '0;
         HDI       <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         HOST_nCS  <= ncs_d;
         HOST_nWE  <= nwe_d;
         HOST_nOE  <= noe_d;
         HOST_ADD  <= add_d;
         HDI       <= hdi_d;
         req_ready <= ready_d;
         busy      <= busy_d;
         rsp_valid <= rsp_valid_d;
         if (rsp_valid_d) begin
            rsp_rdata <= RSP_W'(rbuf_d);
         end
      end
   end

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master
// Directed bench for host_bus_master. dut0 uses default timing (1/3/1/1),
// dut1 uses SETUP=0, STROBE=3, HOLD=0, IDLE=0. Each request is traced cycle
// by cycle (cycle k = interval after accept edge k-1) into low/high masks and
// a list of strobe beats, then compared against hand-computed values.
// Wide-access expectations follow HOST_BUS_MASTER_WIDE_EN.

module tb_host_bus_master;

   logic        clk;
   logic        nRESET;

   logic        v0, we0, wide0, v1, we1, wide1;
   logic [20:0] addr0, addr1;
   logic [63:0] wdata0, wdata1;
   logic        ready0, rv0, busy0, ncs0, nwe0, noe0;
   logic        ready1, rv1, busy1, ncs1, nwe1, noe1;
   logic [63:0] rdata0, rdata1;
   logic [20:0] add0, add1;
   logic [15:0] hdi0, hdi1, hdo0, hdo1;

   logic [15:0] hdo_val;
   logic        hdo_xor;

   int n_tests;
   int n_fail;

   // Trace results of the last request
   logic [63:0] m_ncs, m_nwe, m_noe, m_rv, m_busy;
   int          first_ready;
   logic [63:0] rdata_at_rv, rdata_end;
   int          n_st, n_chg, viol;
   logic [20:0] st_add [8];
   logic [15:0] st_hdi [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus read model: data only while nOE is low, optionally mixed with address
   assign hdo0 = noe0 ? 16'h0000 : (hdo_val ^ (hdo_xor ? add0[15:0] : 16'h0000));
   assign hdo1 = noe1 ? 16'h0000 : (hdo_val ^ (hdo_xor ? add1[15:0] : 16'h0000));

   host_bus_master dut0 (
      .clk(clk), .nRESET(nRESET),
      .req_valid(v0), .req_ready(ready0), .req_we(we0), .req_wide(wide0),
      .req_addr(addr0), .req_wdata(wdata0),
      .rsp_valid(rv0), .rsp_rdata(rdata0), .busy(busy0),
      .HOST_nCS(ncs0), .HOST_nWE(nwe0), .HOST_nOE(noe0),
      .HOST_ADD(add0), .HDI(hdi0), .HDO(hdo0)
   );

   host_bus_master #(
      .SETUP_CYC(0), .STROBE_CYC(3), .HOLD_CYC(0), .IDLE_CYC(0)
   ) dut1 (
      .clk(clk), .nRESET(nRESET),
      .req_valid(v1), .req_ready(ready1), .req_we(we1), .req_wide(wide1),
      .req_addr(addr1), .req_wdata(wdata1),
      .rsp_valid(rv1), .rsp_rdata(rdata1), .busy(busy1),
      .HOST_nCS(ncs1), .HOST_nWE(nwe1), .HOST_nOE(noe1),
      .HOST_ADD(add1), .HDI(hdi1), .HDO(hdo1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request on dut <sel> and trace ncyc cycles after the accept edge
   task automatic run(input int sel, input logic we, input logic wide,
                      input logic [20:0] addr, input logic [63:0] wdata, input int ncyc);
      logic        c_ncs, c_nwe, c_noe, c_rv, c_rdy, c_busy, c_str, p_ncs, p_str;
      logic [20:0] c_add, p_add;
      logic [15:0] c_hdi, p_hdi;
      logic [63:0] c_rd;
      m_ncs = '0; m_nwe = '0; m_noe = '0; m_rv = '0; m_busy = '0;
      first_ready = -1; rdata_at_rv = '0; rdata_end = '0;
      n_st = 0; n_chg = 0; viol = 0;
      p_ncs = 1'b1; p_str = 1'b0; p_add = '0; p_hdi = '0;
      @(negedge clk);
      if (sel == 0) begin
         v0 = 1'b1; we0 = we; wide0 = wide; addr0 = addr; wdata0 = wdata;
      end else begin
         v1 = 1'b1; we1 = we; wide1 = wide; addr1 = addr; wdata1 = wdata;
      end
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) begin
            v0 = 1'b0;
            v1 = 1'b0;
         end
         if (sel == 0) begin
            c_ncs = ncs0; c_nwe = nwe0; c_noe = noe0; c_rv = rv0; c_rdy = ready0;
            c_busy = busy0; c_add = add0; c_hdi = hdi0; c_rd = rdata0;
         end else begin
            c_ncs = ncs1; c_nwe = nwe1; c_noe = noe1; c_rv = rv1; c_rdy = ready1;
            c_busy = busy1; c_add = add1; c_hdi = hdi1; c_rd = rdata1;
         end
         m_ncs[k]  = !c_ncs;
         m_nwe[k]  = !c_nwe;
         m_noe[k]  = !c_noe;
         m_rv[k]   = c_rv;
         m_busy[k] = c_busy;
         if (c_rv) rdata_at_rv = c_rd;
         if (c_rdy && first_ready < 0) first_ready = k;
         if ((!c_nwe && !c_noe) || (c_ncs && (!c_nwe || !c_noe))) viol++;
         c_str = !c_nwe || !c_noe;
         if (c_str && (!p_str || c_add != p_add) && n_st < 8) begin
            st_add[n_st] = c_add;
            st_hdi[n_st] = c_hdi;
            n_st++;
         end
         if (!c_ncs && !p_ncs && (c_add != p_add || c_hdi != p_hdi)) n_chg++;
         p_ncs = c_ncs; p_str = c_str; p_add = c_add; p_hdi = c_hdi;
         rdata_end = c_rd;
      end
   endtask

   initial begin
      int rv_cnt;
      n_tests = 0; n_fail = 0;
      v0 = 0; we0 = 0; wide0 = 0; addr0 = '0; wdata0 = '0;
      v1 = 0; we1 = 0; wide1 = 0; addr1 = '0; wdata1 = '0;
      hdo_val = 16'h0000; hdo_xor = 1'b0;
      nRESET = 1'b0;

      // Reset state, during and after reset
      #12;
      check("rst_strobes", 64'({ncs0, nwe0, noe0}), 64'h7);
      check("rst_add", 64'(add0), 64'h0);
      check("rst_hdi", 64'(hdi0), 64'h0);
      check("rst_ready", 64'(ready0), 64'h1);
      check("rst_busy", 64'(busy0), 64'h0);
      check("rst_rv", 64'(rv0), 64'h0);
      check("rst_rdata", rdata0, 64'h0);
      @(negedge clk);
      nRESET = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_strobes", 64'({ncs0, nwe0, noe0, ncs1, nwe1, noe1}), 64'h3F);
      check("idle_add", 64'(add0), 64'h0);
      check("idle_ready", 64'({ready0, ready1}), 64'h3);
      check("idle_busy", 64'({busy0, busy1}), 64'h0);

      // Default write; upper wdata must not reach the bus
      run(0, 1'b1, 1'b0, 21'h01000, 64'hFFFF_0000_0000_0003, 8);
      check("wr_ncs", m_ncs, 64'h3E);
      check("wr_nwe", m_nwe, 64'h1C);
      check("wr_noe", m_noe, 64'h0);
      check("wr_rv", m_rv, 64'h40);
      check("wr_busy", m_busy, 64'h7E);
      check("wr_ready", 64'(first_ready), 64'd7);
      check("wr_nst", 64'(n_st), 64'd1);
      check("wr_add", 64'(st_add[0]), 64'h01000);
      check("wr_hdi", 64'(st_hdi[0]), 64'h0003);
      check("wr_stable", 64'(n_chg), 64'd0);
      check("wr_viol", 64'(viol), 64'd0);

      // Default read
      hdo_val = 16'hBEEF;
      run(0, 1'b0, 1'b0, 21'h00006, 64'h0, 8);
      check("rd_noe", m_noe, 64'h1C);
      check("rd_nwe", m_nwe, 64'h0);
      check("rd_ncs", m_ncs, 64'h3E);
      check("rd_rv", m_rv, 64'h40);
      check("rd_ready", 64'(first_ready), 64'd7);
      check("rd_add", 64'(st_add[0]), 64'h00006);
      check("rd_hdi", 64'(st_hdi[0]), 64'h0);
      check("rd_rdata", rdata_at_rv, 64'h0000_0000_0000_BEEF);
      check("rd_hold", rdata_end, 64'h0000_0000_0000_BEEF);
      check("rd_viol", 64'(viol), 64'd0);

      // Wide write
      run(0, 1'b1, 1'b1, 21'h00000, 64'h1111_2222_3333_4444, 27);
`ifdef HOST_BUS_MASTER_WIDE_EN
      check("ww_ncs", m_ncs, 64'hFBEFBE);
      check("ww_nwe", m_nwe, 64'h71C71C);
      check("ww_rv", m_rv, 64'h1000000);
      check("ww_ready", 64'(first_ready), 64'd25);
      check("ww_nst", 64'(n_st), 64'd4);
      for (int b = 0; b < 4; b++) begin
         logic [15:0] exp_d;
         exp_d = 16'(16'h4444 - 16'(b) * 16'h1111);
         check("ww_add", 64'(st_add[b]), 64'(2 * b));
         check("ww_hdi", 64'(st_hdi[b]), 64'(exp_d));
      end
`else
      check("ww_ncs", m_ncs, 64'h3E);
      check("ww_nwe", m_nwe, 64'h1C);
      check("ww_rv", m_rv, 64'h40);
      check("ww_ready", 64'(first_ready), 64'd7);
      check("ww_nst", 64'(n_st), 64'd1);
      check("ww_add", 64'(st_add[0]), 64'h0);
      check("ww_hdi", 64'(st_hdi[0]), 64'h4444);
`endif
      check("ww_noe", m_noe, 64'h0);
      check("ww_viol", 64'(viol), 64'd0);

      // Wide read with address wrap on the zero-setup/hold/idle instance
      hdo_val = 16'h1234;
      hdo_xor = 1'b1;
      run(1, 1'b0, 1'b1, 21'h1FFFFC, 64'h0, 15);
`ifdef HOST_BUS_MASTER_WIDE_EN
      check("wrap_ncs", m_ncs, 64'h1FFE);
      check("wrap_noe", m_noe, 64'h1FFE);
      check("wrap_rv", m_rv, 64'h2000);
      check("wrap_ready", 64'(first_ready), 64'd13);
      check("wrap_nst", 64'(n_st), 64'd4);
      check("wrap_add0", 64'(st_add[0]), 64'h1FFFFC);
      check("wrap_add1", 64'(st_add[1]), 64'h1FFFFE);
      check("wrap_add2", 64'(st_add[2]), 64'h000000);
      check("wrap_add3", 64'(st_add[3]), 64'h000002);
      check("wrap_chg", 64'(n_chg), 64'd3);
      check("wrap_rdata", rdata_at_rv, 64'h1236_1234_EDCA_EDC8);
`else
      check("wrap_ncs", m_ncs, 64'hE);
      check("wrap_noe", m_noe, 64'hE);
      check("wrap_rv", m_rv, 64'h10);
      check("wrap_ready", 64'(first_ready), 64'd4);
      check("wrap_nst", 64'(n_st), 64'd1);
      check("wrap_add0", 64'(st_add[0]), 64'h1FFFFC);
      check("wrap_rdata", rdata_at_rv, 64'h0000_0000_0000_EDC8);
`endif
      check("wrap_nwe", m_nwe, 64'h0);
      check("wrap_viol", 64'(viol), 64'd0);
      hdo_xor = 1'b0;

      // Abort: reset in the middle of a write strobe
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b1; wide0 = 1'b0; addr0 = 21'h00100; wdata0 = 64'h55AA;
      @(posedge clk);
      @(negedge clk);
      v0 = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_pre_nwe", 64'(nwe0), 64'h0);
      #2 nRESET = 1'b0;
      #1;
      check("abort_ncs", 64'(ncs0), 64'h1);
      check("abort_nwe", 64'(nwe0), 64'h1);
      check("abort_busy", 64'(busy0), 64'h0);
      repeat (2) @(negedge clk);
      nRESET = 1'b1;
      rv_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rv0) rv_cnt++;
      end
      check("abort_no_rv", 64'(rv_cnt), 64'd0);
      check("abort_ready", 64'(ready0), 64'h1);

      // Normal write after the abort
      run(0, 1'b1, 1'b0, 21'h00200, 64'h0000_0000_0000_7777, 8);
      check("post_nwe", m_nwe, 64'h1C);
      check("post_rv", m_rv, 64'h40);
      check("post_ready", 64'(first_ready), 64'd7);
      check("post_add", 64'(st_add[0]), 64'h00200);
      check("post_hdi", 64'(st_hdi[0]), 64'h7777);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
